ir_packet_gen: RTL and testbench

//  Downstream of car selection: takes the selected CarSettings struct and a 4-bit drive command and

---
 rtl/ir_packet_gen.sv | 179 +++++++++++++++++
 tb/tb_ir_packet_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_gen.sv
// IR packet generator: sends one packet per packet-rate tick. Each packet is
// START, SELECT, RIGHT, LEFT, BACK and FWD carrier bursts with a gap between
// consecutive bursts. Every burst is made from the selected car's carrier.

package ir_packet_pkg;

    // Per-car IR timing. The half period is in clocks. All other fields are in carrier periods.
    typedef struct packed {
        logic [15:0] carrierHalfPeriod;
        logic [7:0]  startBurst;
        logic [7:0]  carSelectBurst;
        logic [7:0]  gapSize;
        logic [7:0]  assertBurst;
        logic [7:0]  deassertBurst;
    } CarSettings;

endpackage

module ir_packet_gen
    import ir_packet_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned PACKET_RATE_HZ = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  CarSettings selectedCar,
    input  logic [3:0] COMMAND,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       PACKET_DONE
);

    localparam int unsigned PERIOD  = CLK_FREQ_HZ / PACKET_RATE_HZ;
    localparam int unsigned TW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] TICK_AT = TW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_GAP, S_SELECT, S_RIGHT, S_LEFT, S_BACK, S_FWD
    } state_t;

    state_t      state, state_next;
    logic [TW-1:0] timer;
    logic        tick;
    CarSettings  cfg, next_cfg;
    logic [3:0]  cmd, next_cmd;
    logic [15:0] hcnt, hcnt_next, half_eff;
    logic        half_last;
    logic        carrier, carrier_next;
    logic [7:0]  pcnt, pcnt_next, cur_len, next_len;
    logic [2:0]  idx, idx_next;
    logic        load, seg_done, done_next, ir_next, busy_next;

    // Length, in carrier periods, of the segment played in a given state.
    function automatic logic [7:0] seg_len(input state_t s, input CarSettings c, input logic [3:0] cm);
        case (s)
            S_START:  seg_len = c.startBurst;
            S_GAP:    seg_len = c.gapSize;
            S_SELECT: seg_len = c.carSelectBurst;
            S_RIGHT:  seg_len = cm[0] ? c.assertBurst : c.deassertBurst;
            S_LEFT:   seg_len = cm[1] ? c.assertBurst : c.deassertBurst;
            S_BACK:   seg_len = cm[2] ? c.assertBurst : c.deassertBurst;
            S_FWD:    seg_len = cm[3] ? c.assertBurst : c.deassertBurst;
            default:  seg_len = 8'd0;
        endcase
    endfunction

    function automatic logic is_burst(input state_t s);
        is_burst = (s != S_IDLE) && (s != S_GAP);
    endfunction

    assign tick      = (timer == TICK_AT);
    assign half_eff  = (cfg.carrierHalfPeriod == 16'd0) ? 16'd1 : cfg.carrierHalfPeriod;
    assign half_last = (hcnt == half_eff - 16'd1);
    assign cur_len   = seg_len(state, cfg, cmd);
    // A zero-length segment lasts exactly one clock. Otherwise the segment ends when the last period completes.
    assign seg_done  = (cur_len == 8'd0) ||
                       (half_last && !carrier && (({1'b0, pcnt} + 9'd1) == {1'b0, cur_len}));

    // The packet about to start uses the inputs seen on the tick cycle. Otherwise the latched copy is used.
    assign next_cfg  = load ? selectedCar : cfg;
    assign next_cmd  = load ? COMMAND : cmd;
    assign next_len  = seg_len(state_next, next_cfg, next_cmd);
    assign ir_next   = carrier_next && is_burst(state_next) && (next_len != 8'd0);
    assign busy_next = (state_next != S_IDLE);

    // Free-running packet-rate timer. It produces a tick every PERIOD clocks.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
        if (RESET || tick) timer <= '0;
        else               timer <= timer + TW'(1);
    end

    // Capture the car settings and the command when a packet starts. Later changes wait for the next packet.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cfg <= '0;
            cmd <= '0;
        end else if (load) begin
            cfg <= selectedCar;
            cmd <= COMMAND;
        end
    end

    // Next-state logic for the sequencer, the carrier divider and the period counter.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next   = state;
        hcnt_next    = hcnt;
        carrier_next = carrier;
        pcnt_next    = pcnt;
        idx_next     = idx;
        load         = 1'b0;
        done_next    = 1'b0;

        if (state == S_IDLE) begin
            if (tick) begin
                load       = 1'b1;
                state_next = S_START;
                idx_next   = 3'd0;
            end
        end else if (seg_done) begin
            case (state)
                S_GAP: begin
                    idx_next = idx + 3'd1;
                    case (idx)
                        3'd0:    state_next = S_SELECT;
                        3'd1:    state_next = S_RIGHT;
                        3'd2:    state_next = S_LEFT;
                        3'd3:    state_next = S_BACK;
                        default: state_next = S_FWD;
                    endcase
                end
                S_FWD: begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
                default: state_next = S_GAP;
            endcase
        end else begin
            hcnt_next = half_last ? 16'd0 : hcnt + 16'd1;
            if (half_last) begin
                carrier_next = ~carrier;
                if (!carrier) pcnt_next = pcnt + 8'd1;
            end
        end

        // Each segment starts with a fresh counter and a high carrier phase.
        if (state_next != state) begin
            hcnt_next    = 16'd0;
            carrier_next = 1'b1;
            pcnt_next    = 8'd0;
        end
    end

    // State and output registers. Reset aborts any packet in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            hcnt        <= '0;
            carrier     <= 1'b0;
            pcnt        <= '0;
            idx         <= '0;
            IR_LED      <= 1'b0;
            BUSY        <= 1'b0;
            PACKET_DONE <= 1'b0;
        end else begin
            state       <= state_next;
            hcnt        <= hcnt_next;
            carrier     <= carrier_next;
            pcnt        <= pcnt_next;
            idx         <= idx_next;
            IR_LED      <= ir_next;
            BUSY        <= busy_next;
            PACKET_DONE <= done_next;
        end
    end

endmodule

// File: tb/tb_ir_packet_gen.sv
// Testbench for ir_packet_gen. A waveform model checks IR_LED, BUSY and
// PACKET_DONE on every clock. A table of packets checks length and high count.
// Hand sequences cover reset, latching, the packet rate and an overlong packet.

module tb_ir_packet_gen;
    import ir_packet_pkg::*;

    localparam int CLK_FREQ = 10_000;
    localparam int RATE     = 1;
    localparam int PERIOD   = CLK_FREQ / RATE;

    logic       CLK;
    logic       RESET;
    CarSettings car;
    logic [3:0] COMMAND;
    logic       IR_LED, BUSY, PACKET_DONE;

    ir_packet_gen #(.CLK_FREQ_HZ(CLK_FREQ), .PACKET_RATE_HZ(RATE)) dut (
        .CLK(CLK), .RESET(RESET), .selectedCar(car), .COMMAND(COMMAND),
        .IR_LED(IR_LED), .BUSY(BUSY), .PACKET_DONE(PACKET_DONE)
    );

    typedef struct {
        CarSettings car;
        logic [3:0] cmd;
        int         exp_len;
        int         exp_high;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int cyc      = 0;

    // Reference model state.
    bit m_ir, m_busy, m_done;
    int timer_m = 0;
    bit wave_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic CarSettings mk_car(int h, int s, int sel, int g, int a, int d);
        CarSettings c;
        c.carrierHalfPeriod = 16'(h);
        c.startBurst        = 8'(s);
        c.carSelectBurst    = 8'(sel);
        c.gapSize           = 8'(g);
        c.assertBurst       = 8'(a);
        c.deassertBurst     = 8'(d);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
            if (n_err >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
                $finish;
            end
        end
    endtask

    // Build the expected per-clock IR_LED sequence of one whole packet.
    function automatic void build_wave(input CarSettings c, input logic [3:0] cm);
        int lens[11];
        int h;
        bit burst;
        h = (c.carrierHalfPeriod == 16'd0) ? 1 : int'(c.carrierHalfPeriod);
        lens = '{int'(c.startBurst), int'(c.gapSize), int'(c.carSelectBurst), int'(c.gapSize),
                 (cm[0] ? int'(c.assertBurst) : int'(c.deassertBurst)), int'(c.gapSize),
                 (cm[1] ? int'(c.assertBurst) : int'(c.deassertBurst)), int'(c.gapSize),
                 (cm[2] ? int'(c.assertBurst) : int'(c.deassertBurst)), int'(c.gapSize),
                 (cm[3] ? int'(c.assertBurst) : int'(c.deassertBurst))};
        wave_q.delete();
        for (int s = 0; s < 11; s++) begin
            burst = (s % 2 == 0);
            if (lens[s] == 0) wave_q.push_back(1'b0);
            else
                for (int p = 0; p < lens[s]; p++)
                    for (int k = 0; k < 2 * h; k++)
                        wave_q.push_back(burst && (k < h));
        end
    endfunction

    // Update the model on each rising edge. Its outputs are what the DUT should show after that edge.
    initial begin
        bit tick;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RESET) begin
                timer_m = 0;
                wave_q.delete();
                m_busy = 0; m_done = 0; m_ir = 0;
            end else begin
                tick    = (timer_m == PERIOD - 1);
                timer_m = (timer_m + 1) % PERIOD;
                m_done  = 0;
                if (m_busy) begin
                    if (wave_q.size() == 0) begin
                        m_busy = 0; m_done = 1; m_ir = 0;
                    end else m_ir = wave_q.pop_front();
                end else if (tick) begin
                    build_wave(car, COMMAND);
                    m_ir   = wave_q.pop_front();
                    m_busy = 1;
                end else m_ir = 0;
            end
        end
    end

    // Compare the DUT with the model on every falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            check($sformatf("cycle_%0d", cyc), {29'd0, IR_LED, BUSY, PACKET_DONE},
                  {29'd0, m_ir, m_busy, m_done});
            if (PACKET_DONE === 1'b1) n_done++;
        end
    end

    task automatic wait_busy(output int rise);
        int w = 0;
        while (BUSY !== 1'b1 && w < 3 * PERIOD) begin
            @(negedge CLK);
            w++;
        end
        check("busy_start", {31'd0, BUSY}, 1);
        rise = cyc;
    endtask

    // Measure one packet. If chg is set, change the inputs in the packet's fifth clock.
    task automatic run_packet(input bit chg, input CarSettings ncar, input logic [3:0] ncmd,
                              output int rise, output int len, output int high, output logic done_seen);
        len  = 0;
        high = 0;
        wait_busy(rise);
        while (BUSY === 1'b1 && len < 60000) begin
            len++;
            if (IR_LED === 1'b1) high++;
            if (chg && len == 5) begin
                car     = ncar;
                COMMAND = ncmd;
            end
            @(negedge CLK);
        end
        done_seen = PACKET_DONE;
    endtask

    initial begin
        vec_t       vecs[4];
        CarSettings ovl_car;
        int         rel, rise, len, high, exp_rise;
        logic       done_seen;

        vecs[0] = '{mk_car(2, 4, 3, 1, 2, 1), 4'b1001, 72, 26};
        vecs[1] = '{mk_car(1, 2, 2, 0, 3, 0), 4'b0101, 27, 10};
        vecs[2] = '{mk_car(0, 1, 1, 0, 1, 2), 4'b0011, 21, 8};
        vecs[3] = '{mk_car(3, 0, 0, 0, 0, 0), 4'b1111, 11, 0};
        // START alone lasts 10200 clocks, so this packet runs past the next tick.
        ovl_car = mk_car(20, 255, 1, 1, 1, 1);

        RESET   = 1'b1;
        car     = mk_car(1, 1, 1, 1, 1, 1);
        COMMAND = 4'd0;
        repeat (5) @(negedge CLK);
        check("reset_ir", {31'd0, IR_LED}, 0);
        check("reset_busy", {31'd0, BUSY}, 0);
        check("reset_done", {31'd0, PACKET_DONE}, 0);

        // Reset in the middle of a random packet aborts it at once.
        car = mk_car($urandom_range(1, 3), $urandom_range(3, 6), $urandom_range(1, 4),
                     $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 4));
        COMMAND = 4'($urandom_range(0, 15));
        RESET = 1'b0;
        rel   = cyc;
        wait_busy(rise);
        check("victim_rise", rise, rel + PERIOD);
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("rst_busy", {31'd0, BUSY}, 0);
            check("rst_ir", {31'd0, IR_LED}, 0);
            check("rst_done", {31'd0, PACKET_DONE}, 0);
        end
        car      = vecs[0].car;
        COMMAND  = vecs[0].cmd;
        RESET    = 1'b0;
        exp_rise = cyc + PERIOD;

        // Table packets, one per tick. In the last one the inputs change mid-packet.
        for (int i = 0; i < 4; i++) begin
            car     = vecs[i].car;
            COMMAND = vecs[i].cmd;
            run_packet(i == 3, ovl_car, 4'b1010, rise, len, high, done_seen);
            check($sformatf("vec%0d_rise", i), rise, exp_rise);
            check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
            check($sformatf("vec%0d_high", i), high, vecs[i].exp_high);
            check($sformatf("vec%0d_done", i), {31'd0, done_seen}, 1);
            exp_rise = rise + PERIOD;
        end

        // The overlong packet uses the settings applied mid-packet above.
        run_packet(1'b0, ovl_car, 4'b0000, rise, len, high, done_seen);
        check("ovl_rise", rise, exp_rise);
        check("ovl_len", len, 10600);
        check("ovl_high", high, 5200);
        check("ovl_done", {31'd0, done_seen}, 1);
        exp_rise = rise + 2 * PERIOD;

        // The tick during the overlong packet is dropped. The next packet starts one tick later.
        car = mk_car($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5));
        COMMAND = 4'($urandom_range(0, 15));
        run_packet(1'b0, car, COMMAND, rise, len, high, done_seen);
        check("last_rise", rise, exp_rise);
        check("last_done", {31'd0, done_seen}, 1);

        repeat (3) @(negedge CLK);
        check("done_pulses", n_done, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
